// File: rtl/fx2_slave_fifo_ctrl.sv
// fx2_slave_fifo_ctrl: bridge between the FX2 slave-FIFO bus and a local
// rx FIFO (host->FPGA) and a show-ahead tx FIFO (FPGA->host).
// Reads and writes share the bus through round-robin grants of at most
// PKT_WORDS words. Short IN packets are committed with PKTEND.
// Optional feature macro: SFIFO_PKTEND_TIMEOUT_EN (idle timer that commits a
// short IN packet automatically after TMO_CYC idle cycles).
module fx2_slave_fifo_ctrl #(
   parameter int         DW        = 16,
   parameter logic [1:0] RD_ADDR   = 2'b00,
   parameter logic [1:0] WR_ADDR   = 2'b10,
   parameter int         PKT_WORDS = 256,
   parameter int         TMO_CYC   = 1024
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          FLAG_EMPTY,
   input  logic          FLAG_FULL,
   inout  wire  [DW-1:0] FD,
   output logic          SLOE,
   output logic          SLRD,
   output logic          SLWR,
   output logic          PKTEND,
   output logic [1:0]    FIFOADR,
   output logic [DW-1:0] rx_data,
   output logic          rx_wrreq,
   input  logic          rx_full,
   input  logic [DW-1:0] tx_data,
   output logic          tx_rdreq,
   input  logic          tx_empty,
   input  logic          tx_commit,
   output logic [2:0]    state_monitor
);

   localparam int            CW      = $clog2(PKT_WORDS + 1);
   localparam logic [CW-1:0] PKT_MAX = CW'(PKT_WORDS);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RD_SETUP  = 3'd1,
      ST_RD_SAMPLE = 3'd2,
      ST_RD_STROBE = 3'd3,
      ST_WR_SETUP  = 3'd4,
      ST_WR_CHECK  = 3'd5,
      ST_WR_STROBE = 3'd6,
      ST_PKT_END   = 3'd7
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    fifoadr_q, fifoadr_d;
   logic          sloe_q, sloe_d;
   logic          slrd_q, slrd_d;
   logic          slwr_q, slwr_d;
   logic          pktend_q, pktend_d;
   logic          rx_wrreq_q, rx_wrreq_d;
   logic          tx_rdreq_q, tx_rdreq_d;
   logic [DW-1:0] rx_data_q, rx_data_d;
   logic [DW-1:0] fd_out_q, fd_out_d;
   logic [CW-1:0] burst_q, burst_d;
   logic [CW-1:0] wr_cnt_q, wr_cnt_d;
   logic          commit_pend_q, commit_pend_d;
   logic          last_served_q, last_served_d;   // 0 = read, 1 = write
   logic          rd_req, wr_req, end_req;
   logic          drive_en;
   logic          tmo_hit;

`ifdef SFIFO_PKTEND_TIMEOUT_EN
   localparam int            TW       = $clog2(TMO_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
   logic [TW-1:0] tmr_q, tmr_d;

   // Idle timer: counts idle cycles with a partial IN packet and nothing left to send
   always_comb begin
      tmr_d   = tmr_q;
      tmo_hit = 1'b0;
      if (slwr_q) begin
         tmr_d = '0;
      end else if (state_q == ST_IDLE && wr_cnt_q != '0 && tx_empty) begin
         if (tmr_q == TMO_LAST) begin
            tmr_d   = '0;
            tmo_hit = 1'b1;
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
      end
   end

   // Idle timer register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) tmr_q <= '0;
      else      tmr_q <= tmr_d;
   end
`else
   // No timer in this build: the comparison is always false
   assign tmo_hit = (TMO_CYC < 0);
`endif

   assign rd_req   = !FLAG_EMPTY && !rx_full;
   assign wr_req   = !FLAG_FULL && !tx_empty;
   assign end_req  = commit_pend_q && (wr_cnt_q != '0);
   assign drive_en = (state_q == ST_WR_CHECK) || (state_q == ST_WR_STROBE);

   assign FD            = drive_en ? fd_out_q : {DW{1'bz}};
   assign SLOE          = sloe_q;
   assign SLRD          = slrd_q;
   assign SLWR          = slwr_q;
   assign PKTEND        = pktend_q;
   assign FIFOADR       = fifoadr_q;
   assign rx_data       = rx_data_q;
   assign rx_wrreq      = rx_wrreq_q;
   assign tx_rdreq      = tx_rdreq_q;
   assign state_monitor = state_q;

   // Next-state and registered-output logic for the bus sequencer
   always_comb begin
      state_d       = state_q;
      fifoadr_d     = fifoadr_q;
      sloe_d        = sloe_q;
      slrd_d        = slrd_q;
      slwr_d        = slwr_q;
      pktend_d      = 1'b0;
      rx_wrreq_d    = rx_wrreq_q;
      tx_rdreq_d    = tx_rdreq_q;
      rx_data_d     = rx_data_q;
      fd_out_d      = fd_out_q;
      burst_d       = burst_q;
      wr_cnt_d      = wr_cnt_q;
      last_served_d = last_served_q;
      case (state_q)
         ST_IDLE: begin
            if (end_req) begin
               fifoadr_d = WR_ADDR;
               state_d   = ST_PKT_END;
            end else if (rd_req && (!wr_req || last_served_q)) begin
               fifoadr_d = RD_ADDR;
               state_d   = ST_RD_SETUP;
            end else if (wr_req) begin
               fifoadr_d = WR_ADDR;
               state_d   = ST_WR_SETUP;
            end
         end
         ST_RD_SETUP: begin
            sloe_d  = 1'b1;
            burst_d = '0;
            state_d = ST_RD_SAMPLE;
         end
         ST_RD_SAMPLE: begin
            if (rd_req && burst_q < PKT_MAX) begin
               rx_data_d  = FD;
               rx_wrreq_d = 1'b1;
               slrd_d     = 1'b1;
               burst_d    = burst_q + 1'b1;
               state_d    = ST_RD_STROBE;
            end else begin
               sloe_d        = 1'b0;
               last_served_d = 1'b0;
               state_d       = ST_IDLE;
            end
         end
         ST_RD_STROBE: begin
            slrd_d     = 1'b0;
            rx_wrreq_d = 1'b0;
            state_d    = ST_RD_SAMPLE;
         end
         ST_WR_SETUP: begin
            burst_d = '0;
            state_d = ST_WR_CHECK;
         end
         ST_WR_CHECK: begin
            if (wr_req && burst_q < PKT_MAX) begin
               fd_out_d   = tx_data;
               slwr_d     = 1'b1;
               tx_rdreq_d = 1'b1;
               burst_d    = burst_q + 1'b1;
               wr_cnt_d   = wr_cnt_q + 1'b1;
               state_d    = ST_WR_STROBE;
            end else begin
               last_served_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         ST_WR_STROBE: begin
            slwr_d     = 1'b0;
            tx_rdreq_d = 1'b0;
            if (wr_cnt_q == PKT_MAX) wr_cnt_d = '0;
            state_d = ST_WR_CHECK;
         end
         ST_PKT_END: begin
            pktend_d = 1'b1;
            wr_cnt_d = '0;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A commit only survives while the packet still holds data, which drops
      // zero-length commits and ones absorbed by a full-packet autocommit
      commit_pend_d = (commit_pend_q || tx_commit || tmo_hit) && (wr_cnt_d != '0);
   end

   // State and output registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q       <= ST_IDLE;
         fifoadr_q     <= RD_ADDR;
         sloe_q        <= 1'b0;
         slrd_q        <= 1'b0;
         slwr_q        <= 1'b0;
         pktend_q      <= 1'b0;
         rx_wrreq_q    <= 1'b0;
         tx_rdreq_q    <= 1'b0;
         rx_data_q     <= '0;
         fd_out_q      <= '0;
         burst_q       <= '0;
         wr_cnt_q      <= '0;
         commit_pend_q <= 1'b0;
         last_served_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         fifoadr_q     <= fifoadr_d;
         sloe_q        <= sloe_d;
         slrd_q        <= slrd_d;
         slwr_q        <= slwr_d;
         pktend_q      <= pktend_d;
         rx_wrreq_q    <= rx_wrreq_d;
         tx_rdreq_q    <= tx_rdreq_d;
         rx_data_q     <= rx_data_d;
         fd_out_q      <= fd_out_d;
         burst_q       <= burst_d;
         wr_cnt_q      <= wr_cnt_d;
         commit_pend_q <= commit_pend_d;
         last_served_q <= last_served_d;
      end
   end

endmodule

// File: tb/tb_fx2_slave_fifo_ctrl.sv
// Testbench for fx2_slave_fifo_ctrl: behavioural FX2 endpoint and local FIFO
// models around the DUT, directed phases with random data and lengths.
module tb_fx2_slave_fifo_ctrl;

   localparam int PKT = 256;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        FLAG_EMPTY = 1'b1;
   logic        FLAG_FULL = 1'b0;
   logic        rx_full = 1'b0;
   logic        tx_empty = 1'b1;
   logic        tx_commit = 1'b0;
   logic [15:0] tx_data = 16'h0;
   logic [15:0] fx2_head = 16'h0;
   wire  [15:0] FD;
   logic        SLOE, SLRD, SLWR, PKTEND, rx_wrreq, tx_rdreq;
   logic [1:0]  FIFOADR;
   logic [15:0] rx_data;
   logic [2:0]  state_monitor;

   logic [15:0] out_q[$], tx_q[$], exp_rx[$], exp_in[$], rx_got[$], in_got[$];
   int          rd_bursts[$], wr_bursts[$], grant_log[$], slrd_cyc[$];
   int          cyc = 0, cur_rd = 0, cur_wr = 0, n_slwr = 0, n_pktend = 0, prev_state = 0;
   logic [15:0] model_tmp;
   int          n_cmp = 0, n_err = 0;
   int          exp_pk = 0, rem = 0;

   fx2_slave_fifo_ctrl dut (
      .CLK(CLK), .RST(RST), .FLAG_EMPTY(FLAG_EMPTY), .FLAG_FULL(FLAG_FULL), .FD(FD),
      .SLOE(SLOE), .SLRD(SLRD), .SLWR(SLWR), .PKTEND(PKTEND), .FIFOADR(FIFOADR),
      .rx_data(rx_data), .rx_wrreq(rx_wrreq), .rx_full(rx_full), .tx_data(tx_data),
      .tx_rdreq(tx_rdreq), .tx_empty(tx_empty), .tx_commit(tx_commit),
      .state_monitor(state_monitor)
   );

   // FX2 drives the bus whenever its output enable is asserted
   assign FD = SLOE ? fx2_head : 16'hzzzz;

   // Free-running clock and cycle counter
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Behavioural FX2 endpoints and local FIFOs, reacting mid-cycle to strobes
   always @(negedge CLK) begin
      if (RST) begin
         if (SLRD) begin
            slrd_cyc.push_back(cyc);
            if (out_q.size() > 0) model_tmp = out_q.pop_front();
            cur_rd++;
         end
         if (rx_wrreq) rx_got.push_back(rx_data);
         if (SLWR) begin
            in_got.push_back(FD);
            cur_wr++;
            n_slwr++;
         end
         if (tx_rdreq && tx_q.size() > 0) model_tmp = tx_q.pop_front();
         if (PKTEND) n_pktend++;
         if (prev_state == 0 && state_monitor == 3'd1) grant_log.push_back(0);
         if (prev_state == 0 && state_monitor == 3'd4) grant_log.push_back(1);
         prev_state = int'(state_monitor);
         if (state_monitor == 3'd0) begin
            if (cur_rd > 0) rd_bursts.push_back(cur_rd);
            if (cur_wr > 0) wr_bursts.push_back(cur_wr);
            cur_rd = 0;
            cur_wr = 0;
         end
      end
      FLAG_EMPTY = (out_q.size() == 0);
      fx2_head   = (out_q.size() > 0) ? out_q[0] : 16'h0;
      tx_empty   = (tx_q.size() == 0);
      tx_data    = (tx_q.size() > 0) ? tx_q[0] : 16'h0;
   end

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Load random words into the OUT endpoint and the local tx FIFO
   task automatic applyStimulus(input int n_out, input int n_tx);
      logic [15:0] w;
      for (int i = 0; i < n_out; i++) begin
         w = 16'($urandom);
         out_q.push_back(w);
         exp_rx.push_back(w);
      end
      for (int i = 0; i < n_tx; i++) begin
         w = 16'($urandom);
         tx_q.push_back(w);
         exp_in.push_back(w);
      end
   endtask

   // Commit the current IN packet and account for it in the model
   task automatic pulseCommit(input string tag);
      tx_commit = 1'b1;
      tick();
      tx_commit = 1'b0;
      repeat (10) tick();
      if (rem != 0) exp_pk++;
      rem = 0;
      checkOutput({tag, "_pktend"}, n_pktend, exp_pk);
      checkOutput({tag, "_wrcnt"}, dut.wr_cnt_q, rem);
   endtask

   function automatic int queueErrors(input logic [15:0] got[$], input logic [15:0] exp[$]);
      int bad = 0;
      if (got.size() != exp.size()) bad++;
      for (int i = 0; i < exp.size(); i++)
         if (i >= got.size() || got[i] !== exp[i]) bad++;
      return bad;
   endfunction

   initial begin
      int k, bad, base, n_rd, n_wr, slwr_at, slwr_ph;

      // Reset held with data waiting in the OUT endpoint
      for (int i = 1; i <= 4; i++) begin
         out_q.push_back(16'(i * 16'h1111));
         exp_rx.push_back(16'(i * 16'h1111));
      end
      repeat (3) tick();
      checkOutput("rst_flag_empty", FLAG_EMPTY, 0);
      checkOutput("rst_sloe", SLOE, 0);
      checkOutput("rst_slrd", SLRD, 0);
      checkOutput("rst_slwr", SLWR, 0);
      checkOutput("rst_pktend", PKTEND, 0);
      checkOutput("rst_rx_wrreq", rx_wrreq, 0);
      checkOutput("rst_tx_rdreq", tx_rdreq, 0);
      checkOutput("rst_state", state_monitor, 0);
      checkOutput("rst_fifoadr", FIFOADR, 2'b00);
      checkOutput("rst_fd_released", dut.drive_en, 0);
      RST = 1'b1;
      tick();
      checkOutput("rd_setup_after_rst", state_monitor, 1);

      // Four-word read burst
      for (k = 0; k < 100 && !(rx_got.size() == 4 && state_monitor == 3'd0); k++) tick();
      checkOutput("rd4_done", (rx_got.size() == 4 && state_monitor == 3'd0), 1);
      checkOutput("rd4_data", queueErrors(rx_got, exp_rx), 0);
      checkOutput("rd4_slrd_count", slrd_cyc.size(), 4);
      bad = 0;
      for (int i = 1; i < slrd_cyc.size(); i++) if (slrd_cyc[i] - slrd_cyc[i-1] != 2) bad++;
      checkOutput("rd4_slrd_spacing", bad, 0);
      checkOutput("rd4_sloe_off", SLOE, 0);
      checkOutput("rd4_flag_empty", FLAG_EMPTY, 1);

      // 300 words: one full autocommitted packet, then 44 on the next grant
      wr_bursts.delete();
      applyStimulus(0, 300);
      for (k = 0; k < 2000 && !(in_got.size() == 300 && state_monitor == 3'd0 && tx_empty); k++) begin
         tick();
         if (SLWR) checkOutput("wr_fifoadr", FIFOADR, 2'b10);
      end
      checkOutput("wr300_done", (in_got.size() == 300 && state_monitor == 3'd0), 1);
      checkOutput("wr300_bursts", wr_bursts.size(), 2);
      checkOutput("wr300_burst0", (wr_bursts.size() > 0) ? wr_bursts[0] : -1, PKT);
      checkOutput("wr300_burst1", (wr_bursts.size() > 1) ? wr_bursts[1] : -1, 300 - PKT);
      checkOutput("wr300_no_pktend", n_pktend, 0);
      checkOutput("wr300_data", queueErrors(in_got, exp_in), 0);
      rem = 300 % PKT;
      checkOutput("wr300_wrcnt", dut.wr_cnt_q, rem);

      // Commit the short packet, then a zero-length commit that must be dropped
      pulseCommit("commit44");
      pulseCommit("commit_empty");

      // Both directions busy: grants alternate, then FLAG_FULL mid-burst
      n_rd = int'($urandom_range(520, 700));
      n_wr = int'($urandom_range(520, 700));
      grant_log.delete();
      rd_bursts.delete();
      wr_bursts.delete();
      slwr_ph = n_slwr;
      applyStimulus(n_rd, n_wr);
      for (k = 0; k < 4000 && grant_log.size() < 5; k++) tick();
      for (k = 0; k < 1000 && state_monitor != 3'd6; k++) tick();
      checkOutput("arb_reach_wr_strobe", state_monitor, 6);
      FLAG_FULL = 1'b1;
      slwr_at = n_slwr;
      tick();
      tick();
      checkOutput("full_exit_idle", state_monitor, 0);
      checkOutput("full_slwr_low", SLWR, 0);
      checkOutput("full_no_more_slwr", n_slwr, slwr_at);
      checkOutput("full_fd_released", dut.drive_en, 0);
      rem = (n_slwr - slwr_ph) % PKT;
      checkOutput("full_wrcnt_kept", dut.wr_cnt_q, rem);
      bad = 0;
      for (int i = 1; i < grant_log.size(); i++) if (grant_log[i] == grant_log[i-1]) bad++;
      checkOutput("arb_alternate", bad, 0);
      checkOutput("arb_grants", (grant_log.size() >= 6), 1);
      checkOutput("arb_rd_burst_cap", (rd_bursts.size() > 0) ? rd_bursts[0] : -1, PKT);
      checkOutput("arb_wr_burst_cap", (wr_bursts.size() > 0) ? wr_bursts[0] : -1, PKT);
      FLAG_FULL = 1'b0;
      for (k = 0; k < 4000 && !(tx_empty && FLAG_EMPTY && state_monitor == 3'd0); k++) tick();
      checkOutput("arb_drained", (tx_empty && FLAG_EMPTY && state_monitor == 3'd0), 1);
      checkOutput("arb_rx_data", queueErrors(rx_got, exp_rx), 0);
      checkOutput("arb_in_data", queueErrors(in_got, exp_in), 0);
      rem = (n_slwr - slwr_ph) % PKT;
      checkOutput("arb_wrcnt", dut.wr_cnt_q, rem);
      pulseCommit("arb_commit");

      // Ten words then a long idle gap: PKTEND only with the timeout feature
      applyStimulus(0, 10);
      for (k = 0; k < 100 && !(tx_empty && state_monitor == 3'd0); k++) tick();
      rem = 10;
      repeat (1100) tick();
`ifdef SFIFO_PKTEND_TIMEOUT_EN
      exp_pk++;
      rem = 0;
`endif
      checkOutput("idle_pktend", n_pktend, exp_pk);
      checkOutput("idle_wrcnt", dut.wr_cnt_q, rem);

      // rx_full mid-burst: clean exit with no further strobes
      base = rx_got.size();
      applyStimulus(6, 0);
      for (k = 0; k < 100 && rx_got.size() < base + 2; k++) tick();
      rx_full = 1'b1;
      repeat (4) tick();
      checkOutput("rxfull_words", rx_got.size() - base, 2);
      checkOutput("rxfull_idle", state_monitor, 0);
      checkOutput("rxfull_sloe_off", SLOE, 0);
      rx_full = 1'b0;
      for (k = 0; k < 100 && !(FLAG_EMPTY && state_monitor == 3'd0); k++) tick();
      checkOutput("rxfull_resume_data", queueErrors(rx_got, exp_rx), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fx2_slave_fifo_ctrl.md
Name: fx2_slave_fifo_ctrl

Overview:
Parametrised bridge between the FX2 slave-FIFO bus and two local show-ahead FIFOs: an rx FIFO (host->FPGA) and a tx FIFO (FPGA->host).
- Round-robin arbitration between the read and write directions, with a bounded burst length per grant.
- Counts words in the current IN packet and commits short packets through PKTEND.
- Sits between the FD pad ring and the command/stream FIFOs.

Parameters:
DW, 16, FD and local data width (8 or 16)
RD_ADDR, 2'b00, FIFOADR value for the OUT endpoint (host->FPGA)
WR_ADDR, 2'b10, FIFOADR value for the IN endpoint (FPGA->host)
PKT_WORDS, 256, words per full USB packet; also the maximum burst length per grant
TMO_CYC, 1024, idle cycles before an automatic short-packet commit (optional feature only)

Ports:
CLK  in  1  interface clock (IFCLK domain)
RST  in  1  asynchronous reset, active-low
FLAG_EMPTY  in  1  1 = OUT endpoint empty
FLAG_FULL  in  1  1 = IN endpoint full
FD  inout  DW  slave FIFO data bus
SLOE  out  1  output enable, active-high
SLRD  out  1  read strobe, active-high, one cycle
SLWR  out  1  write strobe, active-high, one cycle
PKTEND  out  1  packet commit, active-high, one cycle
FIFOADR  out  2  endpoint select
rx_data  out  DW  word read from FD
rx_wrreq  out  1  one-cycle write into local rx FIFO
rx_full  in  1  local rx FIFO full
tx_data  in  DW  show-ahead head of local tx FIFO
tx_rdreq  out  1  one-cycle pop of local tx FIFO
tx_empty  in  1  local tx FIFO empty
tx_commit  in  1  one-cycle request to end the current IN packet
state_monitor  out  3  current FSM state encoding

Behaviour:
- Reset values: SLOE, SLRD, SLWR, PKTEND, rx_wrreq and tx_rdreq = 0. FIFOADR = RD_ADDR. FD tri-stated. Counters, commit_pend and last_served = 0. State IDLE.
- FD is driven with the registered fd_out only when drive_en = 1. drive_en is 1 only in WR_CHECK and WR_STROBE, and SLOE is guaranteed 0 in both states.
- State encodings: IDLE 0, RD_SETUP 1, RD_SAMPLE 2, RD_STROBE 3, WR_SETUP 4, WR_CHECK 5, WR_STROBE 6, PKT_END 7.
- Request definitions:
  - rd_req = !FLAG_EMPTY && !rx_full
  - wr_req = !FLAG_FULL && !tx_empty
  - end_req = commit_pend && wr_cnt != 0
- IDLE:
  - Priority is end_req first, then the rd_req/wr_req round robin.
  - end_req: FIFOADR <= WR_ADDR, go to PKT_END.
  - If both rd_req and wr_req are set, serve the direction opposite last_served.
  - A read grant sets FIFOADR <= RD_ADDR and goes to RD_SETUP. A write grant sets FIFOADR <= WR_ADDR and goes to WR_SETUP.
- RD_SETUP: SLOE <= 1, burst <= 0, go to RD_SAMPLE (one cycle of address/OE setup).
- RD_SAMPLE:
  - If rd_req && burst < PKT_WORDS: rx_data <= FD, rx_wrreq <= 1, SLRD <= 1, burst++, go to RD_STROBE.
  - Otherwise: SLOE <= 0, last_served <= read, go to IDLE.
- RD_STROBE: SLRD <= 0, rx_wrreq <= 0, go to RD_SAMPLE. Sustained rate is one word per 2 cycles.
- WR_SETUP: burst <= 0, go to WR_CHECK.
- WR_CHECK:
  - If wr_req && burst < PKT_WORDS: fd_out <= tx_data, SLWR <= 1, tx_rdreq <= 1, burst++, wr_cnt++, go to WR_STROBE.
  - Otherwise: last_served <= write, go to IDLE.
- WR_STROBE:
  - SLWR <= 0, tx_rdreq <= 0.
  - If wr_cnt == PKT_WORDS then wr_cnt <= 0 (the FX2 autocommits full packets; no PKTEND is issued).
  - Go to WR_CHECK.
- PKT_END: PKTEND <= 1 for one cycle, wr_cnt <= 0, commit_pend <= 0, go to IDLE.
- tx_commit:
  - Sets commit_pend, and the request stays pending through read bursts.
  - If wr_cnt == 0 when it is evaluated, it is dropped: no zero-length packet is sent.
  - If it coincides with a write strobe that completes a full packet, it is cleared without a PKTEND.
- FLAG_FULL rising mid-burst: the current strobe completes and the next WR_CHECK exits to IDLE. wr_cnt is kept, so the packet continues on the next grant.
- FLAG_EMPTY rising or rx_full mid-burst: clean exit at RD_SAMPLE, no strobe issued.
- Reset mid-operation: all strobes drop at once, FD goes high-Z, and the partial wr_cnt is discarded.

Optional Feature:
SFIFO_PKTEND_TIMEOUT_EN
- Defined: an idle timer counts while wr_cnt != 0, tx_empty = 1 and the state is IDLE. The timer clears on any write strobe.
- Reaching TMO_CYC sets commit_pend, giving an automatic short-packet commit.
- Not defined: the timer is absent, TMO_CYC is unused, and only tx_commit produces PKTEND.

Test Plan:
- Reset held low with FLAG_EMPTY = 0 -> all strobes 0, FD = Z, state_monitor = 0. After release, RD_SETUP follows on the next cycle.
- OUT endpoint holds 4 words 0x1111..0x4444, rx_full = 0 -> 4 SLRD pulses 2 cycles apart, rx_data matches in order, FLAG_EMPTY = 1 then returns to IDLE with SLOE = 0.
- tx FIFO holds 300 words, FLAG_FULL = 0, PKT_WORDS = 256 -> 256 SLWR pulses, no PKTEND, return to IDLE, then 44 more on the next grant. wr_cnt = 44.
- tx_commit pulsed with wr_cnt = 44 -> exactly one PKTEND pulse, wr_cnt = 0. A second tx_commit with wr_cnt = 0 -> no PKTEND.
- Both directions ready continuously -> read and write grants alternate. FLAG_FULL asserted mid-burst -> SLWR stops within 2 cycles and FD goes Z within 1 cycle of the exit to IDLE.
- With SFIFO_PKTEND_TIMEOUT_EN, 10 words written then tx_empty = 1 for TMO_CYC = 1024 cycles -> PKTEND within 3 cycles after the timeout. Without the macro, no PKTEND occurs.
